fir_sample_writer: RTL

Writer side of the FIR sample circular buffer. Accepts one 18-bit input sample per handshake, stores it in an 8-lane banked buffer of 16384 samples, and pulses `datain_ready` to start one output computation in the FIR MAC engine. While the engine runs, the block serves its read port. `addr_data` is a logical word address with 0 meaning the newest 8 samples. The result is a 144-bit word, newest sample in the MSBs.

---
 rtl/fir_sample_writer.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/fir_sample_writer.sv
// fir_sample_writer: writer side of the FIR sample circular buffer.
// Samples are written one per handshake into 8 interleaved banks; each write
// kicks the FIR MAC engine with a one-cycle datain_ready pulse, after which the
// buffer is held stable and served to the engine's read port until fir_done.
// Optional macro FIR_SAMPLE_WRITER_CLEAR_EN: zero the whole buffer after reset
// so that unfilled history reads as 0.
module fir_sample_writer #(
    parameter int DATA_W = 18,
    parameter int ADDR_W = 11
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [DATA_W-1:0]   sample_in,
    input  logic                sample_valid,
    output logic                sample_ready,
    output logic                datain_ready,
    input  logic                fir_done,
    input  logic [ADDR_W-1:0]   addr_data,
    output logic [8*DATA_W-1:0] datain,
    output logic                busy
);

    localparam int NUM_BANKS = 8;
    localparam int PTR_W     = ADDR_W + 3;
    localparam int DEPTH     = 1 << ADDR_W;

    typedef enum logic [1:0] {
        S_CLEAR = 2'd0,
        S_IDLE  = 2'd1,
        S_START = 2'd2,
        S_BUSY  = 2'd3
    } state_t;

`ifdef FIR_SAMPLE_WRITER_CLEAR_EN
    localparam state_t RESET_STATE = S_CLEAR;
`else
    localparam state_t RESET_STATE = S_IDLE;
`endif

    state_t             state_reg;
    state_t             state_next;
    logic [PTR_W-1:0]   wptr_reg;
    logic               accept;
    logic               clear_active;
    logic [ADDR_W-1:0]  clr_cnt_reg;

    // Read-side address arithmetic, all modulo 2^PTR_W.
    logic [PTR_W-1:0]   newest_idx;
    logic [PTR_W-1:0]   read_base;
    logic [2:0]         rot_reg;
    logic [DATA_W-1:0]  bank_data [NUM_BANKS];
    logic [8*DATA_W-1:0] datain_reg;

    assign accept     = sample_valid && sample_ready;
    assign newest_idx = wptr_reg - PTR_W'(1);
    assign read_base  = newest_idx - {addr_data, 3'b000};

    // State register and write pointer.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= RESET_STATE;
            wptr_reg  <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                wptr_reg <= wptr_reg + PTR_W'(1);
            end
        end
    end

`ifdef FIR_SAMPLE_WRITER_CLEAR_EN
    // Walks the word address through every bank during the post-reset clear.
    always_ff @(posedge clock) begin
        if (reset) begin
            clr_cnt_reg <= '0;
        end else if (state_reg == S_CLEAR) begin
            clr_cnt_reg <= clr_cnt_reg + ADDR_W'(1);
        end
    end
    assign clear_active = (state_reg == S_CLEAR);
`else
    assign clr_cnt_reg  = '0;
    assign clear_active = 1'b0;
`endif

    // Next-state and Moore outputs; outputs are forced low while reset is held.
    always_comb begin
        state_next   = state_reg;
        sample_ready = 1'b0;
        datain_ready = 1'b0;
        busy         = 1'b0;
        case (state_reg)
            S_CLEAR: begin
                busy = 1'b1;
                if (clr_cnt_reg == ADDR_W'(DEPTH - 1)) begin
                    state_next = S_IDLE;
                end
            end
            S_IDLE: begin
                sample_ready = 1'b1;
                if (sample_valid) begin
                    state_next = S_START;
                end
            end
            S_START: begin
                datain_ready = 1'b1;
                busy         = 1'b1;
                state_next   = S_BUSY;
            end
            S_BUSY: begin
                busy = 1'b1;
                if (fir_done) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = RESET_STATE;
            end
        endcase
        if (reset) begin
            sample_ready = 1'b0;
            datain_ready = 1'b0;
            busy         = 1'b0;
        end
    end

    // One simple dual-port RAM per bank. Bank b always serves the lane whose
    // sample index ends in b, so its word address is derived from read_base
    // minus that lane's offset.
    generate
        for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
            localparam logic [2:0] BANK_ID = 3'(gi);

            logic [DATA_W-1:0] mem [DEPTH];
            logic [DATA_W-1:0] rd_q;
            logic [2:0]        lane_off;
            logic [PTR_W-1:0]  rd_idx;
            logic              wr_en;
            logic [ADDR_W-1:0] wr_addr;
            logic [DATA_W-1:0] wr_data;

            assign lane_off = read_base[2:0] - BANK_ID;
            assign rd_idx   = read_base - {{(PTR_W-3){1'b0}}, lane_off};
            assign wr_en    = clear_active || (accept && (wptr_reg[2:0] == BANK_ID));
            assign wr_addr  = clear_active ? clr_cnt_reg : wptr_reg[PTR_W-1:3];
            assign wr_data  = clear_active ? '0 : sample_in;

            // Write port.
            always_ff @(posedge clock) begin
                if (wr_en) begin
                    mem[wr_addr] <= wr_data;
                end
            end

            // Registered read port, read every cycle.
            always_ff @(posedge clock) begin
                rd_q <= mem[rd_idx[PTR_W-1:3]];
            end

            assign bank_data[gi] = rd_q;
        end
    endgenerate

    // Carry the rotation amount alongside the RAM read so the output mux
    // always matches the data it is steering.
    always_ff @(posedge clock) begin
        if (reset) begin
            rot_reg <= '0;
        end else begin
            rot_reg <= read_base[2:0];
        end
    end

    // Rotate banks into lanes: lane k takes bank (s - k) mod 8, newest in MSBs.
    always_ff @(posedge clock) begin
        if (reset) begin
            datain_reg <= '0;
        end else begin
            for (int k = 0; k < NUM_BANKS; k++) begin
                datain_reg[(NUM_BANKS-k)*DATA_W-1 -: DATA_W] <= bank_data[3'(rot_reg - 3'(k))];
            end
        end
    end

    assign datain = datain_reg;

endmodule
